// File: rtl/node_traffic_src.sv
// Per-node NoC packet injector: LFSR-chosen destinations, valid/ready flit link, drain-aware done flag.
// Optional RAND_GAP_EN: per-packet inter-packet gap taken from the LFSR instead of the GAP constant.
module node_traffic_src #(
    parameter int          NODE_ID   = 0,
    parameter int          NUM_NODES = 9,
    parameter int          ADDR_W    = 4,
    parameter int          FLIT_W    = 32,
    parameter int          PKT_LEN   = 4,
    parameter int          GAP       = 2,
    parameter logic [3:0]  GAP_MASK  = 4'hF,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       pkt_cnt,
    output logic              done
);

    localparam logic [15:0] SEED_X   = SEED ^ 16'(NODE_ID);
    localparam logic [15:0] SEED_EFF = (SEED_X == 16'h0000) ? 16'h0001 : SEED_X;
    localparam logic [7:0]  LAST_IDX = 8'(PKT_LEN - 1);
    localparam int unsigned NN       = NUM_NODES;
    localparam int unsigned ME       = NODE_ID;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t      state, state_d;
    logic        sync1, send_s;
    logic [7:0]  seq, seq_d;
    logic [7:0]  flit_idx, idx_d;
    logic [15:0] lfsr, lfsr_d, lfsr_adv;
    logic [15:0] gap_cnt, gap_d, gap_val;
    logic [FLIT_W-1:0] flit_d;
    logic        valid_d, done_d, xfer, head_xfer;
    logic [15:0] cnt_d;

    // Galois form, taps 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [ADDR_W-1:0] pick_dest(input logic [ADDR_W-1:0] v);
        int unsigned d;
        d = 32'(v);
        if (d >= NN) d = d - NN;
        if (d == ME) d = (d + 1 == NN) ? 0 : d + 1;
        return ADDR_W'(d);
    endfunction

    function automatic logic [FLIT_W-1:0] head_flit(input logic [7:0] s, input logic [ADDR_W-1:0] dest);
        logic [FLIT_W-1:0] f;
        f = '0;
        f[31:30] = (PKT_LEN == 1) ? 2'b11 : 2'b01;
        f[29:22] = s;
        f[2*ADDR_W-1:ADDR_W] = ADDR_W'(NODE_ID);
        f[ADDR_W-1:0] = dest;
        return f;
    endfunction

    function automatic logic [FLIT_W-1:0] body_flit(input logic [7:0] s, input logic [7:0] idx);
        logic [FLIT_W-1:0] f;
        f = '0;
        f[31:30] = (idx == LAST_IDX) ? 2'b10 : 2'b00;
        f[29:22] = s;
        f[7:0] = idx;
        return f;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            send_s <= 1'b0;
        end else begin
            sync1  <= send;
            send_s <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_flit  <= '0;
            pkt_cnt   <= '0;
            done      <= 1'b0;
            seq       <= '0;
            flit_idx  <= '0;
            lfsr      <= SEED_EFF;
            gap_cnt   <= '0;
        end else begin
            state     <= state_d;
            out_valid <= valid_d;
            out_flit  <= flit_d;
            pkt_cnt   <= cnt_d;
            done      <= done_d;
            seq       <= seq_d;
            flit_idx  <= idx_d;
            lfsr      <= lfsr_d;
            gap_cnt   <= gap_d;
        end
    end

    always_comb begin
`ifdef RAND_GAP_EN
        gap_val = 16'(lfsr[7:4] & GAP_MASK);
`else
        // GAP_MASK only matters with random gaps; folded in as zero to keep it referenced
        gap_val = 16'(GAP) | 16'(GAP_MASK & 4'h0);
`endif
    end

    always_comb begin
        state_d   = state;
        valid_d   = out_valid;
        flit_d    = out_flit;
        cnt_d     = pkt_cnt;
        seq_d     = seq;
        idx_d     = flit_idx;
        gap_d     = gap_cnt;
        xfer      = out_valid & out_ready;
        head_xfer = xfer && (flit_idx == 8'd0);
        // a head for a back-to-back packet must see the already-advanced LFSR
        lfsr_adv  = head_xfer ? lfsr_step(lfsr) : lfsr;
        lfsr_d    = lfsr_adv;

        case (state)
            S_IDLE: begin
                if (send_s) begin
                    state_d = S_SEND;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    flit_d  = head_flit(seq, pick_dest(lfsr[ADDR_W-1:0]));
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (flit_idx == LAST_IDX) begin
                        cnt_d = pkt_cnt + 16'd1;
                        seq_d = seq + 8'd1;
                        idx_d = '0;
                        if (!send_s) begin
                            state_d = S_IDLE;
                            valid_d = 1'b0;
                        end else if (gap_val == 16'd0) begin
                            flit_d = head_flit(seq + 8'd1, pick_dest(lfsr_adv[ADDR_W-1:0]));
                        end else begin
                            state_d = S_GAP;
                            valid_d = 1'b0;
                            gap_d   = gap_val;
                        end
                    end else begin
                        idx_d  = flit_idx + 8'd1;
                        flit_d = body_flit(seq, flit_idx + 8'd1);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt <= 16'd1) begin
                    gap_d = '0;
                    if (send_s) begin
                        state_d = S_SEND;
                        valid_d = 1'b1;
                        flit_d  = head_flit(seq, pick_dest(lfsr[ADDR_W-1:0]));
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_cnt - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        done_d = (state_d == S_IDLE) && !send_s;
    end

endmodule

// File: tb/tb_node_traffic_src.sv
// Directed self-checking bench for node_traffic_src: two instances (4-flit packets with gap, 1-flit back-to-back).
module tb_node_traffic_src;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_send, a_ready, a_valid, a_done;
    logic [31:0] a_flit;
    logic [15:0] a_cnt;
    logic        b_send, b_ready, b_valid, b_done;
    logic [31:0] b_flit;
    logic [15:0] b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    node_traffic_src #(.NODE_ID(5), .NUM_NODES(9), .ADDR_W(4), .FLIT_W(32), .PKT_LEN(4), .GAP(2)) u_a (
        .clk(clk), .reset(rst), .send(a_send), .out_flit(a_flit), .out_valid(a_valid),
        .out_ready(a_ready), .pkt_cnt(a_cnt), .done(a_done));

    node_traffic_src #(.NODE_ID(8), .NUM_NODES(9), .ADDR_W(4), .FLIT_W(32), .PKT_LEN(1), .GAP(0)) u_b (
        .clk(clk), .reset(rst), .send(b_send), .out_flit(b_flit), .out_valid(b_valid),
        .out_ready(b_ready), .pkt_cnt(b_cnt), .done(b_done));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; a_send = 1'b0; b_send = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        #1;
        chk("reset valid", {31'd0, a_valid}, 32'd0);
        chk("reset flit", a_flit, 32'd0);
        chk("reset cnt", {16'd0, a_cnt}, 32'd0);
        chk("reset done", {31'd0, a_done}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle done", {31'd0, a_done}, 32'd1);
    endtask

    task automatic test_nominal();
        a_send = 1'b1;
        tick();
        chk("lat edge1 valid", {31'd0, a_valid}, 32'd0);
        tick();
        chk("lat edge2 valid", {31'd0, a_valid}, 32'd0);
        tick();
        chk("lat edge3 valid", {31'd0, a_valid}, 32'd1);
        chk("head0 flit", a_flit, 32'h4000_0054);
        chk("running done", {31'd0, a_done}, 32'd0);
        tick(); chk("body1 flit", a_flit, 32'h0000_0001);
        tick(); chk("body2 flit", a_flit, 32'h0000_0002);
        tick(); chk("tail flit", a_flit, 32'h8000_0003);
        chk("cnt before tail", {16'd0, a_cnt}, 32'd0);
        tick();
        chk("gap1 valid", {31'd0, a_valid}, 32'd0);
        chk("cnt after tail", {16'd0, a_cnt}, 32'd1);
        tick(); chk("gap2 valid", {31'd0, a_valid}, 32'd0);
        tick();
        chk("head1 valid", {31'd0, a_valid}, 32'd1);
        chk("head1 flit", a_flit, 32'h4040_0052);
    endtask

    task automatic test_backpressure();
        tick();
        chk("bp body1 flit", a_flit, 32'h0040_0001);
        a_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp hold flit", a_flit, 32'h0040_0001);
            chk("bp hold valid", {31'd0, a_valid}, 32'd1);
            chk("bp hold cnt", {16'd0, a_cnt}, 32'd1);
        end
        a_ready = 1'b1;
        tick(); chk("bp resume body2", a_flit, 32'h0040_0002);
        tick(); chk("bp tail", a_flit, 32'h8040_0003);
        tick(); chk("bp cnt", {16'd0, a_cnt}, 32'd2);
    endtask

    task automatic test_send_drop();
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (a_valid && a_flit == 32'h01C0_0001) found = 1;
        end
        chk("drop find pkt7 body1", {31'd0, found}, 32'd1);
        a_send = 1'b0;
        tick(); chk("drop body2", a_flit, 32'h01C0_0002);
        tick(); chk("drop tail", a_flit, 32'h81C0_0003);
        chk("drop tail done", {31'd0, a_done}, 32'd0);
        tick();
        chk("drop valid off", {31'd0, a_valid}, 32'd0);
        chk("drop cnt", {16'd0, a_cnt}, 32'd8);
        chk("drop done", {31'd0, a_done}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("drop stays idle", {31'd0, a_valid}, 32'd0);
        end
        chk("drop done held", {31'd0, a_done}, 32'd1);
    endtask

    task automatic test_mid_reset();
        bit found = 0;
        a_send = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (a_valid) found = 1;
        end
        chk("mid find head", {31'd0, found}, 32'd1);
        tick();
        #1 rst = 1'b1;
        #1;
        chk("mid reset valid", {31'd0, a_valid}, 32'd0);
        chk("mid reset cnt", {16'd0, a_cnt}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (a_valid) found = 1;
        end
        chk("post reset head seen", {31'd0, found}, 32'd1);
        chk("post reset head flit", a_flit, 32'h4000_0054);
        a_send = 1'b0;
    endtask

    task automatic test_single_flit();
        bit found = 0;
        b_send = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (b_valid) found = 1;
        end
        chk("sf head seen", {31'd0, found}, 32'd1);
        chk("sf flit0", b_flit, 32'hC000_0080);
        tick(); chk("sf flit1", b_flit, 32'hC040_0084);
        tick(); chk("sf flit2", b_flit, 32'hC080_0081);
        for (int i = 3; i < 12; i++) begin
            tick();
            chk("sf no bubble", {31'd0, b_valid}, 32'd1);
            chk("sf type", {30'd0, b_flit[31:30]}, 32'd3);
            chk("sf seq", {24'd0, b_flit[29:22]}, 32'(i % 256));
        end
    endtask

    task automatic test_dest_coverage();
        int seen [0:15];
        int n = 12;
        for (int i = 0; i < 16; i++) seen[i] = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            chk("dc valid", {31'd0, b_valid}, 32'd1);
            chk("dc seq", {24'd0, b_flit[29:22]}, 32'(n % 256));
            checks++;
            if (b_flit[3:0] >= 4'd9 || b_flit[3:0] == 4'd8) begin
                errors++;
                $display("FAIL dc dest range: got %0d expected 0..7", b_flit[3:0]);
            end
            seen[b_flit[3:0]]++;
            n++;
        end
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (seen[d] == 0) begin
                errors++;
                $display("FAIL dc cover dest %0d: got 0 hits expected >=1", d);
            end
        end
        b_send = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (b_valid) n++;
        end
        chk("dc valid drained", {31'd0, b_valid}, 32'd0);
        chk("dc pkt_cnt", {16'd0, b_cnt}, 32'(n % 65536));
        chk("dc done", {31'd0, b_done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_send_drop();
        test_mid_reset();
        test_single_flit();
        test_dest_coverage();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
